// File: rtl/x3q16_pkg.sv
// x3q16 memory controller shared types.
// Request encodings, controller states and window defaults.
package x3q16_pkg;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  localparam logic [15:0] CRIT_ADDR_DEF = 16'hFF00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memctl_state_e;

endpackage

// File: rtl/x3q16_sram.sv
// x3q16 single-port synchronous SRAM, 16-bit words.
// One write enable, one registered read port.
module x3q16_sram #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/x3q16_memctl.sv
// x3q16 memory responder: fixed-latency SRAM access
// for the core's single-outstanding request bus.
module x3q16_memctl
  import x3q16_pkg::*;
#(
  parameter int          ADDR_BITS     = 10,
  parameter int          LATENCY       = 2,
  parameter logic [15:0] CRITICAL_ADDR = CRIT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        request,
  input  logic        request_type,
  input  logic [15:0] request_address,
  input  logic [15:0] data_in,
  output logic [15:0] memory_in,
  output logic        memory_ready,
  output logic        write_complete,
  output logic        memory_critical,
  output logic        busy,
  output logic        overrun,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        load_ack
);

  localparam logic [16:0] DEPTH  = 17'(1) << ADDR_BITS;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  memctl_state_e state;
  logic [3:0]    cnt;
  logic          type_q;
  logic [15:0]   addr_q;
  logic [15:0]   data_q;
  logic          zero_q;
  logic [15:0]   sram_rdata;

  logic          accept;
  logic          fire;
  logic          preload;
  logic          op_type;
  logic [15:0]   op_addr;
  logic [15:0]   op_data;
  logic          op_in_range;
  logic          ld_in_range;

  logic                 sram_we;
  logic                 sram_re;
  logic [ADDR_BITS-1:0] sram_addr;
  logic [15:0]          sram_wdata;

  assign accept  = (state == IDLE) && request;
  assign preload = (state == IDLE) && !request && load_en;

  // The access happens on the edge that raises the strobe,
  // which for LATENCY=1 is the request edge itself.
  assign fire = (accept && (LATENCY == 1)) ||
                ((state == WAIT) && (cnt == 4'd1));

  assign op_type = (state == IDLE) ? request_type    : type_q;
  assign op_addr = (state == IDLE) ? request_address : addr_q;
  assign op_data = (state == IDLE) ? data_in         : data_q;

  assign op_in_range = {1'b0, op_addr} < DEPTH;
  assign ld_in_range = {1'b0, load_addr} < DEPTH;

  assign sram_we = reset_n &&
                   ((fire && (op_type == REQ_WRITE) && op_in_range) ||
                    (preload && ld_in_range));
  assign sram_re = reset_n && fire &&
                   (op_type == REQ_READ) && op_in_range;

  assign sram_addr  = preload ? load_addr[ADDR_BITS-1:0]
                              : op_addr[ADDR_BITS-1:0];
  assign sram_wdata = preload ? load_data : op_data;

  // Read port only moves on reads, so it holds between responses.
  assign memory_in = zero_q ? 16'h0000 : sram_rdata;

  x3q16_sram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk  (clk),
    .we   (sram_we),
    .re   (sram_re),
    .addr (sram_addr),
    .wdata(sram_wdata),
    .rdata(sram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      type_q          <= REQ_READ;
      addr_q          <= '0;
      data_q          <= '0;
      zero_q          <= 1'b1;
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
      load_ack        <= 1'b0;
    end else begin
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      load_ack        <= preload;
      if (request && (state != IDLE)) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (request) begin
            type_q <= request_type;
            addr_q <= request_address;
            data_q <= data_in;
            cnt    <= LAT_M1;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: cnt <= cnt - 4'd1;
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (fire) begin
        state <= RESP;
        busy  <= 1'b1;
        if (op_type == REQ_READ) begin
          memory_ready <= 1'b1;
          zero_q       <= !op_in_range;
        end else begin
          write_complete  <= 1'b1;
          memory_critical <= op_addr >= CRITICAL_ADDR;
        end
      end
    end
  end

endmodule
